// File: rtl/vga_scanout_if.sv
// Framebuffer read-port bundle between the scanout stage and the block RAM.
interface vga_scanout_if #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned DATA_WIDTH = 12
);
   logic                  fb_en;
   logic [ADDR_WIDTH-1:0] fb_addr;
   logic [DATA_WIDTH-1:0] fb_data;

   modport master (output fb_en, output fb_addr, input  fb_data);
   modport slave  (input  fb_en, input  fb_addr, output fb_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and framebuffer reader with 2^SCALE_SHIFT
// pixel/line upscaling. Outputs are registered two pixel-enables after the
// counter position they describe, matching the registered RAM read.
module vga_scanout #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned SCALE_SHIFT = 3,
   parameter int unsigned FB_WIDTH    = 80,
   parameter int unsigned ADDR_WIDTH  = 13,
   parameter int unsigned DATA_WIDTH  = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_ce,
   vga_scanout_if.master fb,
   output logic [3:0]    red,
   output logic [3:0]    green,
   output logic [3:0]    blue,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic          frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_START_C = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ROW_C    = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_START_C = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_WIDTH-1:0] FB_W_C = ADDR_WIDTH'(FB_WIDTH);

   logic [HW-1:0]         h;
   logic [VW-1:0]         v;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] addr_hold;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic                  active;
   logic                  h_last;
   logic                  v_last;
   logic                  hs_on;
   logic                  vs_on;
   logic                  row_step;
   logic                  s1_active;
   logic                  s1_hs_on;
   logic                  s1_vs_on;

   // Decode the current counter position.
   always_comb begin
      active   = (h < H_ACT_C) && (v < V_ACT_C);
      h_last   = (h == H_LAST_C);
      v_last   = (v == V_LAST_C);
      hs_on    = (h >= HS_START_C) && (h < HS_END_C);
      vs_on    = (v >= VS_START_C) && (v < VS_END_C);
      // Leaving the last line of a stored row; the final active line is
      // excluded so the row base never points past the framebuffer.
      row_step = h_last && (v[SCALE_SHIFT-1:0] == '1) && (v < V_ROW_C);
      cur_addr = row_base + ADDR_WIDTH'(h >> SCALE_SHIFT);
   end

   // Horizontal and vertical position counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (pix_ce) begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   // Row base address: advances one framebuffer row per 2^SCALE_SHIFT lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_base <= '0;
      end else if (pix_ce && h_last) begin
         if (v_last) begin
            row_base <= '0;
         end else if (row_step) begin
            row_base <= row_base + FB_W_C;
         end
      end
   end

   // Remember the last active address so fb_addr is stable in blanking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_hold <= '0;
      end else if (pix_ce && active) begin
         addr_hold <= cur_addr;
      end
   end

   // RAM enable and frame marker are gated by reset so both read 0 while held.
   assign fb.fb_en   = pix_ce && active && rst_n;
   assign fb.fb_addr = active ? cur_addr : addr_hold;
   assign frame_start = pix_ce && rst_n && (h == '0) && (v == '0);

   // Stage 1: capture position attributes alongside the RAM address sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_active <= 1'b0;
         s1_hs_on  <= 1'b0;
         s1_vs_on  <= 1'b0;
      end else if (pix_ce) begin
         s1_active <= active;
         s1_hs_on  <= hs_on;
         s1_vs_on  <= vs_on;
      end
   end

   // Stage 2: output registers, colour taken from the RAM's registered data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
         blank <= 1'b1;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (pix_ce) begin
         if (s1_active) begin
            red   <= fb.fb_data[11:8];
            green <= fb.fb_data[7:4];
            blue  <= fb.fb_data[3:0];
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
         blank <= !s1_active;
         hsync <= !s1_hs_on;
         vsync <= !s1_vs_on;
      end
   end

endmodule
